eth_csr_avmm_bridge: RTL
========================

// Module: eth_csr_avmm_bridge
// PURPOSE
//  Converts the AFU's ETH command word (eth_ctrl_addr/eth_wr_data, already synchronised into clk) into
//  single Avalon-MM transactions on the Ethernet MAC/PHY management port.
//  Returns read data on eth_rd_data to the AFU CSR block.
//  Sits between the AFU CSR block and the eth_e2e_e10 management slave.
//  Adds a bounded-wait timeout and sticky error status.
// PARAMETERS
//  ADDR_W          16     Avalon-MM word address width, taken from eth_ctrl_addr[ADDR_W-1:0]
//  TIMEOUT_CYCLES  1024   max cycles to wait for waitrequest low / readdatavalid; 0 disables timeout
// PORTS
//  clk                input   1       single clock, all logic synchronous to it
//  reset              input   1       synchronous, active-high
//  eth_ctrl_addr      input   32      [17]=write cmd, [16]=read cmd, [ADDR_W-1:0]=address
//  eth_wr_data        input   32      write data, sampled when a write command is accepted
//  eth_rd_data        output  32      data from the last completed read
//  cmd_busy           output  1       transaction in flight (accepted, not yet completed)
//  cmd_err            output  1       sticky: timeout or illegal command since last reset
//  avmm_address       output  ADDR_W  Avalon-MM address
//  avmm_read          output  1       Avalon-MM read request
//  avmm_write         output  1       Avalon-MM write request
//  avmm_writedata     output  32      Avalon-MM write data
//  avmm_readdata      input   32      Avalon-MM read data
//  avmm_waitrequest   input   1       slave stall; a request is held while high
//  avmm_readdatavalid input   1       qualifies avmm_readdata (pipelined read)
// BEHAVIOUR
//  Reset: all outputs 0. State=IDLE, timeout counter=0.
//  cmd = eth_ctrl_addr[17:16]; a command is "present" when cmd != 0.
//  FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT, RELEASE.
//  IDLE, cmd present:
//   - Address and data are captured into avmm_address/avmm_writedata at that edge.
//   - cmd_busy=1 and the request strobe rise the next cycle (1-cycle accept latency).
//   - cmd==2'b10 -> WR_REQ; cmd==2'b01 -> RD_REQ.
//   - cmd==2'b11 -> no transaction; cmd_err<=1; go to RELEASE.
//  WR_REQ:
//   - avmm_write=1 until a cycle with avmm_waitrequest=0. That cycle completes the write.
//   - Next: avmm_write=0, cmd_busy=0, go to RELEASE.
//  RD_REQ:
//   - avmm_read=1 until avmm_waitrequest=0, then go to RD_WAIT with avmm_read=0.
//   - If avmm_readdatavalid=1 in the same cycle as acceptance, the read completes immediately.
//  RD_WAIT:
//   - On avmm_readdatavalid=1: eth_rd_data<=avmm_readdata, cmd_busy<=0, go to RELEASE.
//  RELEASE:
//   - Wait until cmd==0, then return to IDLE.
//   - A level held high never issues a second transaction. The command must drop to re-arm.
//  Timeout:
//   - The counter clears on entry to WR_REQ/RD_REQ and counts every cycle in WR_REQ/RD_REQ/RD_WAIT.
//   - At TIMEOUT_CYCLES-1: deassert requests, cmd_busy<=0, cmd_err<=1, eth_rd_data<=32'hDEAD_BEEF on reads,
//     then go to RELEASE.
//  Stray avmm_readdatavalid outside RD_WAIT, e.g. a late response after a timeout: ignored.
//  Address/writedata are stable for the whole request. Command bits changing mid-transaction are ignored.
//  Only one outstanding transaction at any time.
//  Address bits above ADDR_W and eth_ctrl_addr[31:18] are ignored.
//  Reset asserted mid-transaction: requests drop the next edge and the FSM returns to IDLE.
//   The slave must tolerate the abandoned request.
//  cmd_err clears only on reset.
// TESTING
//  1. Write, no stall:
//     ctrl=0x0002_0010, wr=0xA5A5_0001, waitreq=0
//     -> avmm_write=1 for 1 cycle, addr=0x0010, wdata=0xA5A5_0001; busy 1 cycle.
//  2. Read with stall:
//     ctrl=0x0001_0020, waitreq high for 3 cycles, readdatavalid 2 cycles after accept with 0x1234_5678
//     -> avmm_read held 4 cycles; eth_rd_data=0x1234_5678; busy then falls.
//  3. Held command:
//     ctrl=0x0002_0004 held 50 cycles -> exactly one write.
//     Drop to 0, re-raise -> second write.
//  4. Timeout:
//     TIMEOUT_CYCLES=16, read with waitreq stuck high -> avmm_read drops after 16 cycles,
//     eth_rd_data=0xDEAD_BEEF, cmd_err=1; stays 1 across later good reads.
//  5. Illegal command:
//     ctrl=0x0003_0008 -> no avmm_read/avmm_write strobe, cmd_err=1; FSM re-arms after cmd returns to 0.
//  6. Reset mid-read (RD_WAIT):
//     -> all outputs 0 the next cycle; a late readdatavalid after reset leaves eth_rd_data=0.

Source files
------------

// File: rtl/eth_csr_avmm_bridge.sv
// Bridges the AFU ETH command word onto a single-outstanding Avalon-MM management master,
// with a bounded wait for the slave and a sticky error flag.
module eth_csr_avmm_bridge #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       eth_ctrl_addr,
    input  logic [31:0]       eth_wr_data,
    output logic [31:0]       eth_rd_data,
    output logic              cmd_busy,
    output logic              cmd_err,
    output logic [ADDR_W-1:0] avmm_address,
    output logic              avmm_read,
    output logic              avmm_write,
    output logic [31:0]       avmm_writedata,
    input  logic [31:0]       avmm_readdata,
    input  logic              avmm_waitrequest,
    input  logic              avmm_readdatavalid
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              read_q, read_d;
    logic              write_q, write_d;

    logic [1:0] cmd;
    logic       timeout_hit;
    logic       unused_ctrl;

    assign cmd         = eth_ctrl_addr[17:16];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));
    // Upper command-word bits carry nothing for this block.
    assign unused_ctrl = ^eth_ctrl_addr;

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        err_d   = err_q;
        read_d  = read_q;
        write_d = write_q;

        case (state_q)
            S_IDLE: begin
                if (cmd != 2'b00) begin
                    addr_d  = eth_ctrl_addr[ADDR_W-1:0];
                    wdata_d = eth_wr_data;
                    cnt_d   = '0;
                    case (cmd)
                        2'b10: begin
                            write_d = 1'b1;
                            busy_d  = 1'b1;
                            state_d = S_WR_REQ;
                        end
                        2'b01: begin
                            read_d  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = S_RD_REQ;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_RELEASE;
                        end
                    endcase
                end
            end

            S_WR_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!avmm_waitrequest) begin
                    write_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_RELEASE;
                end else if (timeout_hit) begin
                    write_d = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end

            S_RD_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!avmm_waitrequest) begin
                    read_d = 1'b0;
                    // Pipelined slaves may return data in the accepting cycle.
                    if (avmm_readdatavalid) begin
                        rdata_d = avmm_readdata;
                        busy_d  = 1'b0;
                        state_d = S_RELEASE;
                    end else if (timeout_hit) begin
                        rdata_d = TIMEOUT_RDATA;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end else if (timeout_hit) begin
                    read_d  = 1'b0;
                    rdata_d = TIMEOUT_RDATA;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end

            S_RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (avmm_readdatavalid) begin
                    rdata_d = avmm_readdata;
                    busy_d  = 1'b0;
                    state_d = S_RELEASE;
                end else if (timeout_hit) begin
                    rdata_d = TIMEOUT_RDATA;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end

            S_RELEASE: begin
                // A held command level must drop before the next one is accepted.
                if (cmd == 2'b00) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign eth_rd_data    = rdata_q;
    assign cmd_busy       = busy_q;
    assign cmd_err        = err_q;
    assign avmm_address   = addr_q;
    assign avmm_read      = read_q;
    assign avmm_write     = write_q;
    assign avmm_writedata = wdata_q;

endmodule
